// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin time-sharing of one multiplier
//
// Purpose: arbitrates NREQ requesters onto a single external combinational
// WxW multiplier. A granted operand pair is registered onto mul_a/mul_b, the
// product is captured one cycle later and returned on a tagged response
// channel that honours backpressure.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_a, req_b          packed operands, requester i at [i*W +: W]
//   mul_a, mul_b          registered operands driven to the shared multiplier
//   mul_prod              multiplier result, combinational from mul_a/mul_b
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_prod      owner of the response and its product
//   busy                  high whenever not idle
//   op_count              completed responses, modulo 256
module mul_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [2*W-1:0]    mul_prod,
    output logic              rsp_valid,
    output logic [1:0]        rsp_id,
    output logic [2*W-1:0]    rsp_prod,
    input  logic              rsp_ready,
    output logic              busy,
    output logic [7:0]        op_count
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t         state_q, state_d;
    logic [1:0]     ptr_q;
    logic [W-1:0]   mul_a_q, mul_b_q;
    logic [1:0]     rsp_id_q;
    logic [2*W-1:0] rsp_prod_q;
    logic [7:0]     op_count_q;

    logic           gnt_found;
    logic [1:0]     gnt_idx;
    logic [2:0]     cand;
    logic [W-1:0]   gnt_a, gnt_b;
    logic [1:0]     ptr_next;

    // Round-robin search starting at ptr; cand stays below 2*NREQ so a single
    // conditional subtract implements the modulo.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + 3'(k);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (!gnt_found && req_valid[cand[1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[1:0];
            end
        end
    end

    // Operand mux with constant slices only.
    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == 2'(k)) begin
                gnt_a = req_a[k*W +: W];
                gnt_b = req_b[k*W +: W];
            end
        end
        ptr_next = (gnt_idx == 2'(NREQ-1)) ? 2'd0 : gnt_idx + 2'd1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_found) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic; acceptance is suppressed while reset is asserted so a
    // request is never acknowledged and then discarded.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_found && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                req_ready[k] = (gnt_idx == 2'(k));
            end
        end
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            rsp_id_q   <= '0;
            rsp_prod_q <= '0;
            op_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        mul_a_q  <= gnt_a;
                        mul_b_q  <= gnt_b;
                        rsp_id_q <= gnt_idx;
                        ptr_q    <= ptr_next;
                    end
                end
                CALC: rsp_prod_q <= mul_prod;
                RESP: begin
                    if (rsp_ready) begin
                        op_count_q <= op_count_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_prod = rsp_prod_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      mul_a, mul_b;
    logic [2*W-1:0]    mul_prod;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [2*W-1:0]    rsp_prod;
    logic              rsp_ready;
    logic              busy;
    logic [7:0]        op_count;

    always #5 clk = ~clk;

    assign mul_prod = mul_a * mul_b;

    mul_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_prod(rsp_prod),
        .rsp_ready(rsp_ready), .busy(busy), .op_count(op_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester side
    bit       pend [NREQ];
    bit       keep [NREQ];
    bit [3:0] pa   [NREQ];
    bit [3:0] pb   [NREQ];

    // Transaction-level reference: phase 0 idle, 1 product in flight,
    // 2 response offered.
    int       m_phase, m_ptr, m_cnt, m_id;
    bit [3:0] m_ma, m_mb;
    bit [7:0] m_prod;
    int       grants[$];

    task automatic step(input bit rr, input bit do_rst);
        int g;
        int idx;
        logic [3:0] exp_rdy;
        rst       = do_rst;
        rsp_ready = rr;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]     = pend[i];
            req_a[i*W +: W]  = pa[i];
            req_b[i*W +: W]  = pb[i];
        end
        #1;
        g = -1;
        if (m_phase == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && pend[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (!do_rst && g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (!do_rst) begin
            check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
            check("busy",      32'(busy),      32'(m_phase != 0));
            check("op_count",  32'(op_count),  32'(m_cnt));
            check("mul_a",     32'(mul_a),     32'(m_ma));
            check("mul_b",     32'(mul_b),     32'(m_mb));
            check("rsp_id",    32'(rsp_id),    32'(m_id));
            check("rsp_prod",  32'(rsp_prod),  32'(m_prod));
        end
        @(posedge clk);
        if (do_rst) begin
            m_phase = 0; m_ptr = 0; m_cnt = 0; m_id = 0;
            m_ma = 0; m_mb = 0; m_prod = 0;
        end else begin
            case (m_phase)
                0: if (g >= 0) begin
                    m_ma = pa[g]; m_mb = pb[g]; m_id = g;
                    m_ptr = (g + 1) % NREQ;
                    grants.push_back(g);
                    m_phase = 1;
                    if (keep[g]) begin
                        pa[g] = 4'($urandom); pb[g] = 4'($urandom);
                    end else begin
                        pend[g] = 0;
                    end
                end
                1: begin
                    m_prod  = 8'(int'(m_ma) * int'(m_mb));
                    m_phase = 2;
                end
                default: if (rr) begin
                    m_cnt   = (m_cnt + 1) % 256;
                    m_phase = 0;
                end
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; keep[i] = 0; pa[i] = 0; pb[i] = 0;
        end
        m_phase = 0; m_ptr = 0; m_cnt = 0; m_id = 0;
        m_ma = 0; m_mb = 0; m_prod = 0;
        rst = 1'b1; rsp_ready = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        @(negedge clk);

        // Reset, then idle
        step(0, 1);
        step(0, 1);
        step(0, 0);

        // Single request 15*15 from requester 1
        pend[1] = 1; pa[1] = 4'hF; pb[1] = 4'hF;
        step(1, 0);
        step(1, 0);
        check("t1_prod", 32'(rsp_prod), 32'h E1);
        check("t1_id",   32'(rsp_id),   32'd1);
        step(1, 0);
        check("t1_count", 32'(op_count), 32'd1);

        // All four, a=i+1, b=3, from ptr 0
        step(1, 1);
        grants.delete();
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1; pa[i] = 4'(i + 1); pb[i] = 4'd3;
        end
        for (int c = 0; c < 12; c++) step(1, 0);
        for (int i = 0; i < NREQ; i++) check("rr_order", 32'(grants[i]), 32'(i));

        // Backpressure; ptr should be back at 0 so requester 0 wins first
        grants.delete();
        pend[0] = 1; pa[0] = 4'd7; pb[0] = 4'd6;
        pend[2] = 1; pa[2] = 4'd2; pb[2] = 4'd5;
        step(1, 0);
        step(1, 0);
        for (int c = 0; c < 5; c++) step(0, 0);
        check("bp_prod", 32'(rsp_prod), 32'd42);
        for (int c = 0; c < 6; c++) step(1, 0);
        check("bp_first", 32'(grants[0]), 32'd0);
        check("bp_second", 32'(grants[1]), 32'd2);

        // Fairness between requesters 0 and 3
        step(1, 1);
        grants.delete();
        pend[0] = 1; keep[0] = 1; pa[0] = 4'd3; pb[0] = 4'd4;
        pend[3] = 1; keep[3] = 1; pa[3] = 4'd5; pb[3] = 4'd6;
        for (int c = 0; c < 12; c++) step(1, 0);
        for (int i = 0; i < 4; i++) check("fair_order", 32'(grants[i]), (i % 2 == 0) ? 32'd0 : 32'd3);
        keep[0] = 0; keep[3] = 0; pend[0] = 0; pend[3] = 0;
        for (int c = 0; c < 4; c++) step(1, 0);

        // Reset while 7*9 is in CALC: nothing must come out
        pend[2] = 1; pa[2] = 4'd7; pb[2] = 4'd9;
        step(1, 0);
        step(1, 1);
        for (int c = 0; c < 5; c++) step(1, 0);

        // Random traffic, long enough for op_count to wrap
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1; pa[i] = 4'($urandom); pb[i] = 4'($urandom);
                end
            end
            step($urandom_range(3, 0) != 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
